// File: rtl/ahb_resp_mux.sv
// AHB slave-to-master response multiplexer with built-in default slave that
// returns a two-cycle ERROR for unmapped transfers. AHB_DECERR_LOG_EN adds a sticky decode-error address log.
module ahb_resp_mux (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [8:0]  HSEL,
   input  logic [1:0]  HTRANS,
   input  logic [35:0] HADDR,
   input  logic [63:0] HRDATA_S0,
   input  logic [63:0] HRDATA_S1,
   input  logic [63:0] HRDATA_S2,
   input  logic [63:0] HRDATA_S3,
   input  logic [63:0] HRDATA_S4,
   input  logic [63:0] HRDATA_S5,
   input  logic [63:0] HRDATA_S6,
   input  logic [63:0] HRDATA_S7,
   input  logic        HREADYOUT_S0,
   input  logic        HREADYOUT_S1,
   input  logic        HREADYOUT_S2,
   input  logic        HREADYOUT_S3,
   input  logic        HREADYOUT_S4,
   input  logic        HREADYOUT_S5,
   input  logic        HREADYOUT_S6,
   input  logic        HREADYOUT_S7,
   input  logic        HRESP_S0,
   input  logic        HRESP_S1,
   input  logic        HRESP_S2,
   input  logic        HRESP_S3,
   input  logic        HRESP_S4,
   input  logic        HRESP_S5,
   input  logic        HRESP_S6,
   input  logic        HRESP_S7,
   output logic [63:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP,
   output logic [35:0] ERR_ADDR,
   output logic        ERR_VALID,
   input  logic        ERR_CLR
);

   localparam logic [3:0] SEL_DEF = 4'd8;

   typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dstate_t;

   dstate_t     r_state, w_state_nxt;
   logic [3:0]  r_sel_q;
   logic [3:0]  w_sel_res;
   logic        w_err_start;
   logic [63:0] w_rdata [8];
   logic [7:0]  w_rdy;
   logic [7:0]  w_resp;

   assign w_rdata[0] = HRDATA_S0;
   assign w_rdata[1] = HRDATA_S1;
   assign w_rdata[2] = HRDATA_S2;
   assign w_rdata[3] = HRDATA_S3;
   assign w_rdata[4] = HRDATA_S4;
   assign w_rdata[5] = HRDATA_S5;
   assign w_rdata[6] = HRDATA_S6;
   assign w_rdata[7] = HRDATA_S7;
   assign w_rdy  = {HREADYOUT_S7, HREADYOUT_S6, HREADYOUT_S5, HREADYOUT_S4,
                    HREADYOUT_S3, HREADYOUT_S2, HREADYOUT_S1, HREADYOUT_S0};
   assign w_resp = {HRESP_S7, HRESP_S6, HRESP_S5, HRESP_S4,
                    HRESP_S3, HRESP_S2, HRESP_S1, HRESP_S0};

   // Lowest set bit among slaves 0..7 wins; bit 8 alone or no bit maps to the default slave.
   always_comb begin
      w_sel_res = SEL_DEF;
      for (int i = 7; i >= 0; i--) begin
         if (HSEL[i]) w_sel_res = 4'(i);
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) r_sel_q <= SEL_DEF;
      else if (HREADY) r_sel_q <= w_sel_res;
   end

   assign w_err_start = HREADY && (w_sel_res == SEL_DEF) && HTRANS[1];

   always_ff @(posedge HCLK) begin
      if (HRESET) r_state <= D_IDLE;
      else r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         D_IDLE:  if (w_err_start) w_state_nxt = D_ERR1;
         D_ERR1:  w_state_nxt = D_ERR2;
         D_ERR2:  w_state_nxt = w_err_start ? D_ERR1 : D_IDLE;
         default: w_state_nxt = D_IDLE;
      endcase
   end

   // Data phase response: addressed slave passes straight through, else the default slave.
   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = 1'b0;
      if (r_sel_q != SEL_DEF) begin
         HRDATA = w_rdata[r_sel_q[2:0]];
         HREADY = w_rdy[r_sel_q[2:0]];
         HRESP  = w_resp[r_sel_q[2:0]];
      end else begin
         case (r_state)
            D_ERR1: begin
               HREADY = 1'b0;
               HRESP  = 1'b1;
            end
            D_ERR2: HRESP = 1'b1;
            default: ;
         endcase
      end
   end

`ifdef AHB_DECERR_LOG_EN
   logic [35:0] r_addr_q;
   logic [35:0] r_err_addr;
   logic        r_err_valid;

   always_ff @(posedge HCLK) begin
      if (HRESET) r_addr_q <= '0;
      else if (HREADY) r_addr_q <= HADDR;
   end

   // Capture during the first error cycle; a clear in the same cycle re-arms the capture.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_err_addr  <= '0;
         r_err_valid <= 1'b0;
      end else if ((r_state == D_ERR1) && (!r_err_valid || ERR_CLR)) begin
         r_err_addr  <= r_addr_q;
         r_err_valid <= 1'b1;
      end else if (ERR_CLR) begin
         r_err_addr  <= '0;
         r_err_valid <= 1'b0;
      end
   end

   assign ERR_ADDR  = r_err_addr;
   assign ERR_VALID = r_err_valid;
`else
   logic w_unused;
   assign w_unused  = ^{ERR_CLR, HADDR};
   assign ERR_ADDR  = '0;
   assign ERR_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Directed bench for ahb_resp_mux: stimulus queues expected per-cycle responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ahb_resp_mux;

`ifdef AHB_DECERR_LOG_EN
   localparam bit LOG = 1'b1;
`else
   localparam bit LOG = 1'b0;
`endif

   localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
   localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0000_0001;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic [8:0]  HSEL;
   logic [1:0]  HTRANS;
   logic [35:0] HADDR;
   logic [63:0] hrd [8];
   logic [7:0]  rdy;
   logic [7:0]  rsp;
   logic [63:0] HRDATA;
   logic        HREADY, HRESP;
   logic [35:0] ERR_ADDR;
   logic        ERR_VALID;
   logic        ERR_CLR;

   ahb_resp_mux dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
      .HRDATA_S0(hrd[0]), .HRDATA_S1(hrd[1]), .HRDATA_S2(hrd[2]), .HRDATA_S3(hrd[3]),
      .HRDATA_S4(hrd[4]), .HRDATA_S5(hrd[5]), .HRDATA_S6(hrd[6]), .HRDATA_S7(hrd[7]),
      .HREADYOUT_S0(rdy[0]), .HREADYOUT_S1(rdy[1]), .HREADYOUT_S2(rdy[2]), .HREADYOUT_S3(rdy[3]),
      .HREADYOUT_S4(rdy[4]), .HREADYOUT_S5(rdy[5]), .HREADYOUT_S6(rdy[6]), .HREADYOUT_S7(rdy[7]),
      .HRESP_S0(rsp[0]), .HRESP_S1(rsp[1]), .HRESP_S2(rsp[2]), .HRESP_S3(rsp[3]),
      .HRESP_S4(rsp[4]), .HRESP_S5(rsp[5]), .HRESP_S6(rsp[6]), .HRESP_S7(rsp[7]),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
      .ERR_ADDR(ERR_ADDR), .ERR_VALID(ERR_VALID), .ERR_CLR(ERR_CLR)
   );

   always #5 HCLK = ~HCLK;

   int cyc = 0;
   always @(posedge HCLK) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      string       name;
      bit          is_log;
      logic        rdy;
      logic        rsp;
      logic [63:0] d;
      logic        v;
      logic [35:0] a;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   checks = 0;
   int   failures = 0;

   task automatic exp_bus(input string n, input logic r, input logic s, input logic [63:0] d);
      exp_t e;
      e.cyc = cyc; e.name = n; e.is_log = 1'b0;
      e.rdy = r; e.rsp = s; e.d = d; e.v = 1'b0; e.a = '0;
      q.push_back(e);
   endtask

   task automatic exp_log(input string n, input logic v, input logic [35:0] a);
      exp_t e;
      e.cyc = cyc; e.name = n; e.is_log = 1'b1;
      e.rdy = 1'b0; e.rsp = 1'b0; e.d = '0;
      e.v = LOG ? v : 1'b0; e.a = LOG ? a : 36'h0;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input logic [8:0] s, input logic [1:0] t, input logic [35:0] a);
      HSEL = s; HTRANS = t; HADDR = a;
   endtask

   always @(negedge HCLK) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         me = q.pop_front();
         checks++;
         if (me.cyc < cyc) begin
            failures++;
            $display("FAIL %s: sample missed (cycle %0d, now %0d)", me.name, me.cyc, cyc);
         end else if (me.is_log) begin
            if ({ERR_VALID, ERR_ADDR} !== {me.v, me.a}) begin
               failures++;
               $display("FAIL %s: got valid=%0b addr=%h, want valid=%0b addr=%h",
                        me.name, ERR_VALID, ERR_ADDR, me.v, me.a);
            end
         end else if ({HREADY, HRESP, HRDATA} !== {me.rdy, me.rsp, me.d}) begin
            failures++;
            $display("FAIL %s: got rdy=%0b resp=%0b data=%h, want rdy=%0b resp=%0b data=%h",
                     me.name, HREADY, HRESP, HRDATA, me.rdy, me.rsp, me.d);
         end
      end
   end

   initial begin
      HRESET = 1'b1; ERR_CLR = 1'b0;
      drive(9'h000, IDLE, 36'h0);
      rdy = 8'hFF; rsp = 8'h00;
      for (int i = 0; i < 8; i++) hrd[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
      tick(); tick();
      HRESET = 1'b0;
      exp_bus("reset_bus", 1'b1, 1'b0, 64'h0);
      exp_log("reset_log", 1'b0, 36'h0);
      tick();

      // slave 1 with two wait states
      drive(9'h002, NONSEQ, 36'h0_0000_1000);
      exp_bus("s1_addr", 1'b1, 1'b0, 64'h0);
      tick();
      drive(9'h000, IDLE, 36'h0);
      rdy[1] = 1'b0; hrd[1] = DEAD;
      exp_bus("s1_wait1", 1'b0, 1'b0, DEAD);
      tick();
      exp_bus("s1_wait2", 1'b0, 1'b0, DEAD);
      tick();
      rdy[1] = 1'b1;
      exp_bus("s1_data", 1'b1, 1'b0, DEAD);
      tick();
      exp_bus("s1_after", 1'b1, 1'b0, 64'h0);
      tick();

      // single decode error
      drive(9'h100, NONSEQ, 36'h2_0000_0000);
      exp_bus("s2_addr", 1'b1, 1'b0, 64'h0);
      tick();
      drive(9'h000, IDLE, 36'h0);
      exp_bus("s2_err1", 1'b0, 1'b1, 64'h0);
      tick();
      exp_bus("s2_err2", 1'b1, 1'b1, 64'h0);
      exp_log("s2_log", 1'b1, 36'h2_0000_0000);
      tick();
      exp_bus("s2_idle", 1'b1, 1'b0, 64'h0);
      tick();

      // clear, then back-to-back errors
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0;
      exp_log("s3_clr", 1'b0, 36'h0);
      drive(9'h100, NONSEQ, 36'h3_0000_0010);
      exp_bus("s3_addr", 1'b1, 1'b0, 64'h0);
      tick();
      drive(9'h000, IDLE, 36'h0);
      exp_bus("s3_err1a", 1'b0, 1'b1, 64'h0);
      tick();
      drive(9'h100, SEQ, 36'h3_0000_0020);
      exp_bus("s3_err2a", 1'b1, 1'b1, 64'h0);
      tick();
      drive(9'h000, IDLE, 36'h0);
      exp_bus("s3_err1b", 1'b0, 1'b1, 64'h0);
      tick();
      exp_bus("s3_err2b", 1'b1, 1'b1, 64'h0);
      tick();
      exp_bus("s3_idle", 1'b1, 1'b0, 64'h0);
      exp_log("s3_log_first", 1'b1, 36'h3_0000_0010);
      tick();

      // IDLE and BUSY to the default slave stay OKAY
      drive(9'h100, IDLE, 36'h7_0000_0000);
      exp_bus("s4_idle", 1'b1, 1'b0, 64'h0);
      tick();
      drive(9'h100, BUSY, 36'h7_0000_0008);
      exp_bus("s4_busy", 1'b1, 1'b0, 64'h0);
      tick();
      drive(9'h000, IDLE, 36'h0);
      exp_bus("s4_after", 1'b1, 1'b0, 64'h0);
      tick();

      // reset during the first error cycle
      drive(9'h100, NONSEQ, 36'h4_0000_0000);
      exp_bus("s5_addr", 1'b1, 1'b0, 64'h0);
      tick();
      drive(9'h000, IDLE, 36'h0);
      HRESET = 1'b1;
      exp_bus("s5_err1", 1'b0, 1'b1, 64'h0);
      tick();
      HRESET = 1'b0;
      exp_bus("s5_rst", 1'b1, 1'b0, 64'h0);
      exp_log("s5_log", 1'b0, 36'h0);
      tick();

      // multi-hot select priority and slave ERROR pass-through
      hrd[3] = 64'h3333_3333_3333_3333;
      drive(9'h00C, NONSEQ, 36'h0_0000_2000);
      exp_bus("s6_addr", 1'b1, 1'b0, 64'h0);
      tick();
      drive(9'h000, IDLE, 36'h0);
      rsp[2] = 1'b1;
      exp_bus("s6_lowest", 1'b1, 1'b1, 64'hA5A5_0000_0000_0002);
      tick();
      rsp[2] = 1'b0;
      drive(9'h180, NONSEQ, 36'h0_0000_3000);
      exp_bus("s6_180_addr", 1'b1, 1'b0, 64'h0);
      tick();
      drive(9'h000, IDLE, 36'h0);
      exp_bus("s6_slave7", 1'b1, 1'b0, 64'hA5A5_0000_0000_0007);
      tick();

      // clear coinciding with a new capture
      drive(9'h100, NONSEQ, 36'h5_0000_0100);
      exp_bus("s7_addr", 1'b1, 1'b0, 64'h0);
      tick();
      drive(9'h000, IDLE, 36'h0);
      exp_bus("s7_err1a", 1'b0, 1'b1, 64'h0);
      tick();
      drive(9'h100, NONSEQ, 36'h6_0000_0200);
      exp_bus("s7_err2a", 1'b1, 1'b1, 64'h0);
      exp_log("s7_log_first", 1'b1, 36'h5_0000_0100);
      tick();
      drive(9'h000, IDLE, 36'h0);
      ERR_CLR = 1'b1;
      exp_bus("s7_err1b", 1'b0, 1'b1, 64'h0);
      tick();
      ERR_CLR = 1'b0;
      exp_bus("s7_err2b", 1'b1, 1'b1, 64'h0);
      exp_log("s7_clr_capture", 1'b1, 36'h6_0000_0200);
      tick();
      exp_bus("s7_idle", 1'b1, 1'b0, 64'h0);
      tick();

      @(negedge HCLK);
      #1;
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahb_resp_mux.md
AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 SHALL have these ports, one per line: name, direction, width, meaning; clock and reset first.
- HCLK, in, 1, bus clock; all state updates on the rising edge.
- HRESET, in, 1, synchronous, active-high reset.
- HSEL, in, 9, decoder selects: bits 7..0 are slaves 0..7; bit 8 is the reserved/default slave.
- HTRANS, in, 2, master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HADDR, in, 36, master address-phase address.
- HRDATA_S0..HRDATA_S7, in, 64 each, slave read data.
- HREADYOUT_S0..HREADYOUT_S7, in, 1 each, slave ready.
- HRESP_S0..HRESP_S7, in, 1 each, slave response (0=OKAY, 1=ERROR).
- HRDATA, out, 64, muxed read data to master.
- HREADY, out, 1, muxed ready to master and to all slaves.
- HRESP, out, 1, muxed response to master.
- ERR_ADDR, out, 36, logged error address (macro only).
- ERR_VALID, out, 1, error-log sticky flag (macro only).
- ERR_CLR, in, 1, clears the error log (macro only).

REQ-002 SHALL use one clock, HCLK; reset HRESET is synchronous and active-high.

Function
REQ-003 SHALL register HSEL into data-phase select sel_q only in cycles where HREADY=1; sel_q SHALL hold while HREADY=0.
REQ-004 SHALL resolve HSEL as follows:
- if more than one bit is set, the lowest index wins;
- if HSEL is all zero, it is treated as bit 8.
REQ-005 SHALL drive HRDATA, HREADY and HRESP combinationally from the slave addressed by sel_q when sel_q selects slaves 0..7. This adds zero added latency.
REQ-006 SHALL implement the default slave as an FSM with states D_IDLE, D_ERR1 and D_ERR2.
REQ-007 In D_IDLE with sel_q=8, the default slave SHALL drive HREADY=1, HRESP=0, HRDATA=0.
REQ-008 D_IDLE SHALL go to D_ERR1 when HREADY=1, the resolved HSEL is 8, and HTRANS[1]=1 (NONSEQ/SEQ).
REQ-009 D_ERR1 SHALL drive HREADY=0, HRESP=1, and go to D_ERR2 unconditionally.
REQ-010 D_ERR2 SHALL drive HREADY=1, HRESP=1, and then transition:
- to D_ERR1 if the new address phase targets slave 8 with NONSEQ/SEQ;
- otherwise to D_IDLE.
REQ-011 IDLE or BUSY transfers to any slave SHALL complete as zero-wait OKAY from the addressed slave's outputs. The default slave SHALL NOT enter D_ERR1 for them.
REQ-012 SHALL accept a new address phase during D_ERR2, since HREADY=1. Back-to-back errors therefore take 2 cycles each with no gap.
REQ-013 SHALL pass slave wait states through unchanged; a stalled slave holds sel_q indefinitely.

Reset
REQ-014 On HRESET, the block SHALL set:
- sel_q to 8 and the FSM to D_IDLE;
- HREADY=1, HRESP=0, HRDATA=0;
- ERR_VALID=0, ERR_ADDR=0.
REQ-015 HRESET asserted during D_ERR1 or D_ERR2 SHALL abandon the error response. The next cycle SHALL show HREADY=1, HRESP=0.

Configuration
REQ-016 Macro AHB_DECERR_LOG_EN SHALL control the error log.
- Defined: HADDR is captured alongside sel_q. On entry to D_ERR1, if ERR_VALID=0, the block SHALL load ERR_ADDR with that address and set ERR_VALID=1. The first error is sticky; later errors do not overwrite it.
- Defined: ERR_CLR=1 SHALL zero ERR_ADDR and ERR_VALID on the next edge. A capture in the same cycle as ERR_CLR wins.
- Undefined: ERR_ADDR and ERR_VALID SHALL be tied to 0, ERR_CLR is ignored, and no log registers exist.

Verification
REQ-017 The bench SHALL cover these directed scenarios:
- NONSEQ to slave 1 with HREADYOUT_S1 low 2 cycles and HRDATA_S1=64'hDEAD_BEEF_0000_0001 -> HREADY low 2 cycles, then HRDATA matches, HRESP=0.
- NONSEQ with HSEL=9'h100 and HADDR=36'h2_0000_0000 -> cycle 1 HREADY=0/HRESP=1, cycle 2 HREADY=1/HRESP=1; with macro, ERR_VALID=1 and ERR_ADDR=36'h2_0000_0000.
- Two consecutive NONSEQ to slave 8 -> four cycles ERR1,ERR2,ERR1,ERR2; ERR_ADDR keeps the first address.
- IDLE with HSEL=9'h100 -> HREADY=1, HRESP=0, no FSM transition.
- HRESET asserted in D_ERR1 -> next cycle HREADY=1, HRESP=0, HRDATA=0, ERR_VALID=0.
- HSEL=9'h00C (slaves 2 and 3) -> slave 2 data is returned; ERR_CLR together with a new error -> ERR_VALID stays 1 with the new address.
